imem_loader: RTL and testbench

Streams a program image from an external byte source into the instruction memory before the core runs. It accepts bytes over a valid/ready handshake and assembles them into 32-bit instruction words, most significant byte first, matching the instruction memory's byte order (byte at address 4k is bits 31:24). It issues one write per word at consecutive word-aligned addresses and holds the core in stall until the image is complete. It sits between the board-level download port and the write side of the instruction memory (address, write data, write enable).

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write bus.
//   in_valid       source has a byte on in_data
//   in_data        byte from the source
//   in_ready       loader can accept a byte this cycle
//   mem_address    byte address of the word being written
//   mem_write_data assembled instruction word
//   mem_write      single-cycle write strobe
// Modports: master = loader side, slave = source/memory side.
interface imem_loader_if #(
  parameter int unsigned WORD_LEN = 32
);
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic [WORD_LEN-1:0] mem_address;
  logic [WORD_LEN-1:0] mem_write_data;
  logic                mem_write;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_address, mem_write_data, mem_write
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_address, mem_write_data, mem_write
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams a program image (2-byte big-endian word count, then
// 4 bytes per word, MSB first) into the instruction memory and stalls the
// core until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match the XOR of all payload bytes.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   start         one-cycle pulse, honoured only in IDLE, DONE or ERR
//   bus           imem_loader_if.master (byte handshake + memory write bus)
//   cpu_hold      stalls the core, loader owns the memory write port
//   done          image loaded (held until the next start)
//   error         load aborted (held until the next start)
//   words_loaded  words written so far in the current load
//
// state  | meaning
// IDLE   | waiting for start, nothing loaded
// LEN_HI | accepting word count bits 15:8
// LEN_LO | accepting word count bits 7:0, range check
// DATA   | accepting payload bytes of the current word
// WRITE  | one-cycle write strobe of the assembled word
// CHECK  | accepting checksum byte (checksum build only)
// DONE   | image complete
// ERR    | load aborted
module imem_loader #(
  parameter int unsigned         WORD_LEN  = 32,
  parameter logic [WORD_LEN-1:0] BASE_ADDR = '0,
  parameter int unsigned         MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [15:0]         words_loaded
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  // Where the load goes once the last word (or an empty image) is through.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CHECK;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t              state, state_next;
  logic [15:0]         n_words;
  logic [1:0]          byte_cnt;
  logic [23:0]         shift;
  logic [WORD_LEN-1:0] mem_address_q;
  logic [WORD_LEN-1:0] mem_write_data_q;
  logic                xfer;
  logic                idle_like;
  logic                last_word;
  logic [15:0]         len_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  assign xfer      = bus.in_valid && bus.in_ready;
  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign last_word = (words_loaded + 16'd1) == n_words;
  assign len_full  = {n_words[15:8], bus.in_data};

  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.mem_write = 1'b0;
    cpu_hold      = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        bus.in_ready = 1'b1;
        cpu_hold     = 1'b1;
        if (xfer) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        bus.in_ready = 1'b1;
        cpu_hold     = 1'b1;
        if (xfer) begin
          if (len_full > MAX_N)       state_next = S_ERR;
          else if (len_full == 16'd0) state_next = S_AFTER;
          else                        state_next = S_DATA;
        end
      end
      S_DATA: begin
        bus.in_ready = 1'b1;
        cpu_hold     = 1'b1;
        if (xfer && byte_cnt == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_write = 1'b1;
        cpu_hold      = 1'b1;
        state_next    = last_word ? S_AFTER : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        bus.in_ready = 1'b1;
        cpu_hold     = 1'b1;
        if (xfer) state_next = (bus.in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_next = S_LEN_HI;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      n_words          <= '0;
      byte_cnt         <= '0;
      shift            <= '0;
      words_loaded     <= '0;
      mem_address_q    <= BASE_ADDR;
      mem_write_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum             <= '0;
`endif
    end else begin
      if (idle_like && start) begin
        words_loaded <= '0;
        byte_cnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end
      if (xfer) begin
        case (state)
          S_LEN_HI: n_words[15:8] <= bus.in_data;
          S_LEN_LO: n_words[7:0]  <= bus.in_data;
          S_DATA: begin
            shift    <= {shift[15:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.in_data;
`endif
            // Address and data are latched on the 4th byte so they are
            // stable for the whole WRITE cycle and held afterwards.
            if (byte_cnt == 2'd3) begin
              mem_write_data_q <= WORD_LEN'({shift, bus.in_data});
              mem_address_q    <= BASE_ADDR + WORD_LEN'({words_loaded, 2'b00});
            end
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) words_loaded <= words_loaded + 16'd1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  stm[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  localparam logic [31:0] BASE = 32'h0;
  localparam int          MAXW = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  imem_loader_if #(.WORD_LEN(32)) bus ();

  imem_loader #(.WORD_LEN(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle the strobe is seen high counts as one memory write.
  always @(negedge clk) begin
    if (bus.mem_write === 1'b1) begin
      wq_addr.push_back(bus.mem_address);
      wq_data.push_back(bus.mem_write_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_addr"}, bus.mem_address, BASE);
    chk({tag, "_wdata"}, bus.mem_write_data, 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  // Random image of n words; with the checksum build a trailing XOR byte,
  // optionally corrupted.
  task automatic build_random(input int n, input bit bad_cs);
    logic [7:0] b, cs;
    stm.delete();
    stm.push_back(8'(n >> 8));
    stm.push_back(8'(n));
    cs = 8'h00;
    if (n <= MAXW) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        cs = cs ^ b;
        stm.push_back(b);
      end
      if (CS != 0) stm.push_back(bad_cs ? ~cs : cs);
    end
  endtask

  // mode 0: in_valid held high, 1: toggling, 2: random gaps.
  // abort_at >= 0 pulls reset during the write cycle of that word index.
  task automatic run_load(input string tag, input int mode, input int abort_at);
    int n, exp_wl, exp_bytes, exp_cyc, idx, sc, endc;
    bit exp_err, finished, v, x;
    logic [7:0] cs;
    n = int'({stm[0], stm[1]});
    cs = 8'h00;
    if (n > MAXW) begin
      exp_err   = 1'b1;
      exp_wl    = 0;
      exp_bytes = 2;
      exp_cyc   = 2;
    end else begin
      for (int i = 0; i < 4 * n; i++) cs = cs ^ stm[2 + i];
      exp_err   = (CS != 0) && (stm[2 + 4 * n] != cs);
      exp_wl    = n;
      exp_bytes = 2 + 4 * n + CS;
      exp_cyc   = 2 + 5 * n + CS;
    end
    wq_addr.delete();
    wq_data.delete();
    idx = 0;
    finished = 1'b0;
    endc = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sc = cyc;
    chk({tag, "_hold_rise"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_ready_rise"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_words_clr"}, 32'(words_loaded), 32'd0);
    for (int k = 0; k < 5000; k++) begin
      if (done === 1'b1 || error === 1'b1) begin
        finished = 1'b1;
        endc = cyc;
        break;
      end
      if (abort_at >= 0 && bus.mem_write === 1'b1 && int'(words_loaded) == abort_at) begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset({tag, "_abort"});
        rst = 1'b1;
        return;
      end
      v = (idx < stm.size()) &&
          ((mode == 0) || (mode == 1 && (k % 2) == 0) ||
           (mode == 2 && $urandom_range(0, 3) != 0));
      bus.in_valid = v;
      bus.in_data  = v ? stm[idx] : 8'($urandom);
      x = v && (bus.in_ready === 1'b1);
      @(posedge clk);
      if (x) idx++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk({tag, "_finished"}, 32'(finished), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'(!exp_err));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_hold_fall"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_ready_low"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'(exp_wl));
    chk({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(exp_wl));
    chk({tag, "_bytes"}, 32'(idx), 32'(exp_bytes));
    for (int i = 0; i < exp_wl; i++) begin
      chk({tag, "_addr"}, wq_addr[i], BASE + 32'(4 * i));
      chk({tag, "_data"}, wq_data[i],
          {stm[2 + 4 * i], stm[3 + 4 * i], stm[4 + 4 * i], stm[5 + 4 * i]});
    end
    if (mode == 0) chk({tag, "_latency"}, 32'(endc - sc), 32'(exp_cyc));
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_reset("post_reset");

    stm = '{8'h00, 8'h02, 8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0, 8'h1A, 8'h01};
    if (CS != 0) stm.push_back(8'h0F);
    run_load("two_words", 0, -1);

    stm = '{8'h00, 8'h01, 8'hE3, 8'hA0, 8'h00, 8'h14};
    if (CS != 0) stm.push_back(8'h57);
    run_load("toggle_valid", 1, -1);

    stm = '{8'h01, 8'h01};
    run_load("too_long", 0, -1);

    stm = '{8'h00, 8'h00};
    if (CS != 0) stm.push_back(8'h00);
    run_load("empty", 0, -1);

    if (CS != 0) begin
      stm = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      run_load("cs_good", 0, -1);
      stm = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      run_load("cs_bad", 2, -1);
    end

    stm = '{8'h00, 8'h02, 8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0, 8'h1A, 8'h01};
    if (CS != 0) stm.push_back(8'h0F);
    run_load("abort", 0, 1);
    stm = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CS != 0) stm.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    run_load("restart", 0, -1);

    build_random(MAXW, 1'b0);
    run_load("max_words", 0, -1);
    build_random(MAXW + 1 + int'($urandom_range(0, 1000)), 1'b0);
    run_load("rand_too_long", 2, -1);

    for (int r = 0; r < 8; r++) begin
      build_random(int'($urandom_range(1, 6)), (CS != 0) && ($urandom_range(0, 3) == 0));
      run_load("random", int'($urandom_range(0, 2)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
